inst_fetch: RTL

Instruction-fetch front end of the MIPS pipeline. It owns the architectural PC register, feeds `pc`/`nextpc_en` to the next-PC generator and consumes the `nextpc` it returns. It issues one instruction read at a time on the SRAM-like instruction bus (req/addr_ok/data_ok) and hands fetched instructions to decode under a valid/allowin handshake. It handles exception flushes with outstanding-response cancellation.

---
 rtl/mycpu_pkg.sv | 18 +
 rtl/inst_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   fetch_state_e    : instruction-fetch controller states
//   RESET_PC_DEFAULT : architectural PC after reset (boot ROM vector)
//   NOP_INST         : MIPS NOP encoding (sll $0,$0,0), used as the
//                      empty value of the fetch instruction register
package mycpu_pkg;

  typedef enum logic [1:0] {
    FS_REQ    = 2'd0,  // drive inst_req for pc
    FS_WAIT   = 2'd1,  // one request accepted, response pending
    FS_HOLD   = 2'd2,  // instruction buffered for decode
    FS_CANCEL = 2'd3   // swallow one stale response after a flush
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch front end.
// Owns the architectural PC, issues one read at a time on the SRAM-like
// instruction bus and buffers the returned word for decode.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   pc / nextpc_en         current PC and sequential-advance strobe to the
//                          next-PC generator
//   nextpc                 next PC from the generator (flush target on flush)
//   flush                  exception/ERET redirect
//   inst_req/inst_addr     read request and address (address = pc)
//   inst_addr_ok           request accepted
//   inst_data_ok/rdata     read response
//   fs_valid/fs_pc/fs_inst buffered instruction to decode
//   ds_allowin             decode accepts this cycle
module inst_fetch
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] pc,
  output logic        nextpc_en,
  input  logic [31:0] nextpc,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        ds_allowin
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fs_valid_q, fs_valid_d;
  logic [31:0]  fs_pc_q, fs_pc_d;
  logic [31:0]  fs_inst_q, fs_inst_d;

  // Handoff to decode; a flush in the same cycle overrides it.
  logic handoff;
  assign handoff = (state_q == FS_HOLD) && fs_valid_q && ds_allowin && !flush;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a value unassigned (latch).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;

    unique case (state_q)
      FS_REQ: begin
        if (flush) begin
          pc_d = nextpc;
          // An address accepted this cycle belongs to the old stream.
          if (inst_addr_ok) state_d = FS_CANCEL;
        end else if (inst_addr_ok) begin
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (flush) begin
          pc_d    = nextpc;
          // Data arriving with the flush is simply dropped; otherwise the
          // pending response must still be drained.
          state_d = inst_data_ok ? FS_REQ : FS_CANCEL;
        end else if (inst_data_ok) begin
          fs_inst_d  = inst_rdata;
          fs_pc_d    = pc_q;
          fs_valid_d = 1'b1;
          state_d    = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (flush) begin
          pc_d       = nextpc;
          fs_valid_d = 1'b0;
          state_d    = FS_REQ;
        end else if (handoff) begin
          pc_d       = nextpc;
          fs_valid_d = 1'b0;
          state_d    = FS_REQ;
        end
      end
      FS_CANCEL: begin
        if (flush) pc_d = nextpc;
        if (inst_data_ok) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase

    // A flush always invalidates whatever is buffered.
    if (flush) fs_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FS_REQ;
      pc_q       <= RESET_PC;
      fs_valid_q <= 1'b0;
      fs_pc_q    <= 32'h0;
      fs_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
    end
  end

  // Request is gated by resetn so nothing is issued while reset is held.
  assign inst_req  = (state_q == FS_REQ) && resetn;
  assign inst_addr = pc_q;
  assign pc        = pc_q;
  assign nextpc_en = handoff;
  assign fs_valid  = fs_valid_q;
  assign fs_pc     = fs_pc_q;
  assign fs_inst   = fs_inst_q;

endmodule
